// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the MEM-stage data-memory responder: access sizes,
// FSM states and the latched request record.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Request captured on acceptance; the word index is held separately
    // because its width depends on the array depth.
    typedef struct packed {
        logic        wen;
        size_e       size;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory handshake. The core drives the request side (master),
// the responder drives read data, stall and the error pulse (slave).
interface dmem_responder_if;

    logic        mem_en_i;
    logic        mem_wen_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;
    logic        addr_err_o;

    modport master (
        output mem_en_i, mem_wen_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_stall_o, addr_err_o
    );

    modport slave (
        input  mem_en_i, mem_wen_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_stall_o, addr_err_o
    );

endinterface

// File: rtl/dmem_responder_strobe_gen.sv
// Byte-lane strobe and misalignment decode from access size and the two
// low address bits. Purely combinational.
module dmem_strobe_gen
    import dmem_responder_pkg::*;
(
    input  size_e      size,
    input  logic [1:0] lo,
    output logic [3:0] strobe,
    output logic       misalign
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        strobe   = 4'b0000;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: strobe = 4'b0001 << lo;
            SZ_HALF: begin
                strobe   = 4'b0011 << {lo[1], 1'b0};
                misalign = lo[0];
            end
            SZ_WORD: begin
                strobe   = 4'b1111;
                misalign = (lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, WAIT_CYCLES wait
// states, byte-lane stores and whole-word registered loads.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int WORDS = 2 ** DEPTH_LOG2;

    state_e                  state;
    logic [CNT_W-1:0]        cnt;
    req_t                    req;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [31:0]             rdata;
    logic                    err_q;
    logic [3:0]              strobe;
    logic                    misalign;
    logic                    access;
    logic [3:0][7:0]         mem [WORDS];

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr_i[31:DEPTH_LOG2+2];

    dmem_strobe_gen u_strobe (
        .size     (req.size),
        .lo       (req.lo),
        .strobe   (strobe),
        .misalign (misalign)
    );

    assign access = (state == ST_BUSY) && (cnt == '0);

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            req   <= '0;
            idx   <= '0;
            rdata <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_en_i) begin
                        req   <= '{wen:   bus.mem_wen_i,
                                   size:  size_e'(bus.mem_size_i),
                                   lo:    bus.mem_addr_i[1:0],
                                   wdata: bus.mem_wdata_i};
                        idx   <= bus.mem_addr_i[DEPTH_LOG2+1:2];
                        cnt   <= CNT_W'(WAIT_CYCLES);
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ST_DONE;
                        if (misalign) begin
                            err_q <= 1'b1;
                            rdata <= '0;
                        end else if (!req.wen) begin
                            rdata <= mem[idx];
                        end
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset; contents survive rst, and gating on !rst
    // keeps an access interrupted by reset from writing.
    always_ff @(posedge clk) begin
        if (!rst && access && req.wen && !misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) mem[idx][b] <= req.wdata[8*b +: 8];
            end
        end
    end

    // Stall is also high in the request cycle itself, before acceptance.
    assign bus.mem_stall_o = bus.mem_en_i && (state != ST_DONE) && !rst;
    assign bus.mem_rdata_o = rdata;
    assign bus.addr_err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written flush/reset
// and zero-wait sequences, then random traffic against a byte-level model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: byte-addressed view of the word array.
    logic [31:0] model_mem [1024];
    logic [31:0] last_rd = '0;

    function automatic bit exp_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || ((addr % (32'd1 << size)) != 0);
    endfunction

    task automatic model_access(input bit wen, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output bit er);
        int idx;
        idx = int'((addr >> 2) % 1024);
        er  = exp_err(size, addr);
        if (er) begin
            last_rd = '0;
        end else if (wen) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] ba;
                ba = (addr & ~32'd3) + 32'(b);
                if (ba >= addr && ba < addr + (32'd1 << size))
                    model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            last_rd = model_mem[idx];
        end
        rd = last_rd;
    endtask

    // One access on the WAIT_CYCLES=2 instance, starting just after a clock edge in IDLE.
    task automatic do2(input string tag, input bit wen, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_er);
        int   nst;
        logic pre, er, er_after;
        logic [31:0] rd;
        bus2.mem_en_i    = 1'b1;
        bus2.mem_wen_i   = wen;
        bus2.mem_size_i  = size;
        bus2.mem_addr_i  = addr;
        bus2.mem_wdata_i = wdata;
        #1 pre = bus2.mem_stall_o;
        nst = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!bus2.mem_stall_o) break;
            nst++;
        end
        rd = bus2.mem_rdata_o;
        er = bus2.addr_err_o;
        @(posedge clk); #1;
        er_after = bus2.addr_err_o;
        bus2.mem_en_i = 1'b0;
        check({tag, " stall_req"}, 32'(pre), 32'd1);
        check({tag, " stall_len"}, 32'(nst), 32'd3);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err_done"}, 32'(er), 32'(exp_er));
        check({tag, " err_idle"}, 32'(er_after), 32'd0);
    endtask

    task automatic do0(input string tag, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
        int nst;
        bus0.mem_en_i    = 1'b1;
        bus0.mem_wen_i   = wen;
        bus0.mem_size_i  = 2'd2;
        bus0.mem_addr_i  = addr;
        bus0.mem_wdata_i = wdata;
        nst = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!bus0.mem_stall_o) break;
            nst++;
        end
        check({tag, " stall_len"}, 32'(nst), 32'd1);
        check({tag, " rdata"}, bus0.mem_rdata_o, exp_rd);
        @(posedge clk); #1;
        bus0.mem_en_i = 1'b0;
    endtask

    typedef struct {
        bit          wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_er;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] rd;
        bit          er;
        logic [4:0]  pat;

        tbl[0]  = '{1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd2, 32'h10, 32'h00000000, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 32'h13, 32'hAA000000, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 32'h10, 32'h00005555, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hAA005555, 1'b0};
        tbl[6]  = '{1'b1, 2'd2, 32'h20, 32'hCAFEF00D, 32'hAA005555, 1'b0};
        tbl[7]  = '{1'b1, 2'd2, 32'h22, 32'h12345678, 32'h00000000, 1'b1};
        tbl[8]  = '{1'b0, 2'd2, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[9]  = '{1'b0, 2'd1, 32'h21, 32'h0,        32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 2'd1, 32'h22, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b0, 2'd3, 32'h20, 32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 2'd2, 32'h40, 32'h11111111, 32'h00000000, 1'b0};
        tbl[13] = '{1'b0, 2'd2, 32'h40, 32'h0,        32'h11111111, 1'b0};

        bus2.mem_en_i = 1'b1; bus2.mem_wen_i = 1'b0; bus2.mem_size_i = 2'd2;
        bus2.mem_addr_i = '0; bus2.mem_wdata_i = '0;
        bus0.mem_en_i = 1'b0; bus0.mem_wen_i = 1'b0; bus0.mem_size_i = 2'd2;
        bus0.mem_addr_i = '0; bus0.mem_wdata_i = '0;

        // Reset state, with a request already on the inputs.
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", 32'(bus2.mem_stall_o), 32'd0);
        check("reset rdata", bus2.mem_rdata_o, 32'd0);
        check("reset err", 32'(bus2.addr_err_o), 32'd0);
        bus2.mem_en_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            model_access(tbl[i].wen, tbl[i].size, tbl[i].addr, tbl[i].wdata, rd, er);
            do2($sformatf("vec%0d", i), tbl[i].wen, tbl[i].size, tbl[i].addr,
                tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_er);
        end

        // Flush: request withdrawn during BUSY still commits.
        bus2.mem_en_i = 1'b1; bus2.mem_wen_i = 1'b1; bus2.mem_size_i = 2'd2;
        bus2.mem_addr_i = 32'h30; bus2.mem_wdata_i = 32'h12345678;
        @(posedge clk); #1;
        check("flush stall_busy", 32'(bus2.mem_stall_o), 32'd1);
        bus2.mem_en_i = 1'b0;
        #1 check("flush stall_drop", 32'(bus2.mem_stall_o), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        model_access(1'b1, 2'd2, 32'h30, 32'h12345678, rd, er);
        model_access(1'b0, 2'd2, 32'h30, 32'h0, rd, er);
        do2("flush load", 1'b0, 2'd2, 32'h30, 32'h0, rd, er);

        // Reset during BUSY aborts the store to 0x40.
        bus2.mem_en_i = 1'b1; bus2.mem_wen_i = 1'b1; bus2.mem_size_i = 2'd2;
        bus2.mem_addr_i = 32'h40; bus2.mem_wdata_i = 32'hFFFF0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst stall", 32'(bus2.mem_stall_o), 32'd0);
        check("rst rdata", bus2.mem_rdata_o, 32'd0);
        check("rst err", 32'(bus2.addr_err_o), 32'd0);
        check("rst state", 32'(dut2.state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1 bus2.mem_en_i = 1'b0;
        rst = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        model_access(1'b0, 2'd2, 32'h40, 32'h0, rd, er);
        do2("rst load", 1'b0, 2'd2, 32'h40, 32'h0, rd, er);

        // Zero-wait build: aliasing and back-to-back stall pattern.
        do0("w0 st alias", 1'b1, 32'h1010, 32'h600DF00D, 32'h0);
        do0("w0 st 14", 1'b1, 32'h14, 32'h0BADCAFE, 32'h0);
        bus0.mem_en_i = 1'b1; bus0.mem_wen_i = 1'b0; bus0.mem_addr_i = 32'h14;
        pat = '0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            pat[4-s] = bus0.mem_stall_o;
            if (s == 1) begin
                check("w0 b2b rd14", bus0.mem_rdata_o, 32'h0BADCAFE);
                bus0.mem_addr_i = 32'h10;
            end
        end
        check("w0 b2b pattern", 32'(pat), 32'b10110);
        check("w0 alias rd10", bus0.mem_rdata_o, 32'h600DF00D);
        @(posedge clk); #1;
        bus0.mem_en_i = 1'b0;

        // Random traffic on a 16-word window, with random alias bits above the index.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] a, d;
            a = 32'h100 + 32'(4 * w);
            d = $urandom;
            model_access(1'b1, 2'd2, a, d, rd, er);
            do2($sformatf("pre%0d", w), 1'b1, 2'd2, a, d, rd, er);
        end
        for (int n = 0; n < 40; n++) begin
            bit          wen;
            logic [1:0]  size;
            logic [31:0] a, d;
            wen  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            a    = {20'($urandom), 12'h100 + 12'($urandom_range(0, 63))};
            d    = $urandom;
            model_access(wen, size, a, d, rd, er);
            do2($sformatf("rnd%0d", n), wen, size, a, d, rd, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
